// File: rtl/mcb_cmd_arb.sv
// Two-port memory command arbiter with refresh priority and bus-turnaround spacing.
// Latency: decision in IDLE appears on registered grant/strobe outputs one cycle later.
// Backpressure: requests are levels held until granted; bursts, turnarounds and refresh stall all grants.
module mcb_cmd_arb #(
    parameter int P_RW_GAP = 4,
    parameter int P_WR_GAP = 2,
    parameter int P_RFC    = 7
) (
    input  logic       mcb_clk,
    input  logic       mcb_rst,
    input  logic       p0_req,
    input  logic       p0_wr,
    input  logic       p0_ap,
    input  logic [1:0] p0_bst_num,
    input  logic       p1_req,
    input  logic       p1_wr,
    input  logic       p1_ap,
    input  logic [1:0] p1_bst_num,
    input  logic       ref_req,
    output logic       p0_gnt,
    output logic       p1_gnt,
    output logic       ref_gnt,
    output logic       c_rd,
    output logic       c_rda,
    output logic       c_wr,
    output logic       c_wra,
    output logic [1:0] c_bst_num,
    output logic       arb_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_TURN = 2'd2;
    localparam logic [1:0] S_REF  = 2'd3;

    localparam logic [4:0] RW_GAP = 5'(P_RW_GAP);
    localparam logic [4:0] WR_GAP = 5'(P_WR_GAP);
    localparam logic [4:0] RFC    = 5'(P_RFC);

    logic [1:0] state;
    logic [4:0] cnt;
    logic       rr_ptr;
    logic       last_vld;
    logic       last_wr;

    logic       win_any;
    logic       win_p1;
    logic       win_wr;
    logic       win_ap;
    logic [1:0] win_bst;
    logic [4:0] gap;
    logic       need_turn;

    // rr_ptr = 0 favours p0 when both ports are requesting.
    always_comb begin
        win_any   = p0_req | p1_req;
        win_p1    = p1_req & (~p0_req | rr_ptr);
        win_wr    = win_p1 ? p1_wr : p0_wr;
        win_ap    = win_p1 ? p1_ap : p0_ap;
        win_bst   = win_p1 ? p1_bst_num : p0_bst_num;
        gap       = last_wr ? WR_GAP : RW_GAP;
        need_turn = last_vld & win_any & ~ref_req & (win_wr != last_wr) & (gap != 5'd0);
    end

    assign arb_busy = (state != S_IDLE);

    always_ff @(posedge mcb_clk) begin
        if (mcb_rst) begin
            state     <= S_IDLE;
            cnt       <= 5'd0;
            rr_ptr    <= 1'b0;
            last_vld  <= 1'b0;
            last_wr   <= 1'b0;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            ref_gnt   <= 1'b0;
            c_rd      <= 1'b0;
            c_rda     <= 1'b0;
            c_wr      <= 1'b0;
            c_wra     <= 1'b0;
            c_bst_num <= 2'd0;
        end else begin
            p0_gnt  <= 1'b0;
            p1_gnt  <= 1'b0;
            ref_gnt <= 1'b0;
            c_rd    <= 1'b0;
            c_rda   <= 1'b0;
            c_wr    <= 1'b0;
            c_wra   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ref_req) begin
                        ref_gnt  <= 1'b1;
                        state    <= S_REF;
                        cnt      <= RFC;
                        last_vld <= 1'b0;
                    end else if (win_any) begin
                        p0_gnt    <= ~win_p1;
                        p1_gnt    <= win_p1;
                        c_rd      <= ~win_wr & ~win_ap;
                        c_rda     <= ~win_wr & win_ap;
                        c_wr      <= win_wr & ~win_ap;
                        c_wra     <= win_wr & win_ap;
                        c_bst_num <= win_bst;
                        rr_ptr    <= ~win_p1;
                        state     <= S_BUSY;
                        // (bst+1)*4 - 1 busy edges before the next decision
                        cnt       <= {1'b0, win_bst, 2'b11};
                        last_vld  <= 1'b1;
                        last_wr   <= win_wr;
                    end
                end
                S_BUSY: begin
                    if (cnt <= 5'd1) begin
                        if (need_turn) begin
                            state <= S_TURN;
                            cnt   <= gap;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_TURN, S_REF: begin
                    if (cnt <= 5'd1) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcb_cmd_arb.sv
// Directed vector table plus multi-cycle sequences for the memory command arbiter.
module tb_mcb_cmd_arb;

    logic       mcb_clk = 1'b0;
    logic       mcb_rst = 1'b1;
    logic       p0_req = 1'b0, p0_wr = 1'b0, p0_ap = 1'b0;
    logic [1:0] p0_bst_num = 2'd0;
    logic       p1_req = 1'b0, p1_wr = 1'b0, p1_ap = 1'b0;
    logic [1:0] p1_bst_num = 2'd0;
    logic       ref_req = 1'b0;
    logic       p0_gnt, p1_gnt, ref_gnt;
    logic       c_rd, c_rda, c_wr, c_wra;
    logic [1:0] c_bst_num;
    logic       arb_busy;
    logic [9:0] obs;

    assign obs = {p0_gnt, p1_gnt, ref_gnt, c_rd, c_rda, c_wr, c_wra, c_bst_num, arb_busy};

    mcb_cmd_arb dut (
        .mcb_clk    (mcb_clk),
        .mcb_rst    (mcb_rst),
        .p0_req     (p0_req),
        .p0_wr      (p0_wr),
        .p0_ap      (p0_ap),
        .p0_bst_num (p0_bst_num),
        .p1_req     (p1_req),
        .p1_wr      (p1_wr),
        .p1_ap      (p1_ap),
        .p1_bst_num (p1_bst_num),
        .ref_req    (ref_req),
        .p0_gnt     (p0_gnt),
        .p1_gnt     (p1_gnt),
        .ref_gnt    (ref_gnt),
        .c_rd       (c_rd),
        .c_rda      (c_rda),
        .c_wr       (c_wr),
        .c_wra      (c_wra),
        .c_bst_num  (c_bst_num),
        .arb_busy   (arb_busy)
    );

    always #5 mcb_clk = ~mcb_clk;

    // port field = {req, wr, ap, bst[1:0]}; exp = {p0_gnt,p1_gnt,ref_gnt, rd,rda,wr,wra, bst, busy}
    typedef struct {
        logic       rst;
        logic [4:0] p0;
        logic [4:0] p1;
        logic       rf;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    function automatic vec_t mk(logic rst, logic [4:0] p0, logic [4:0] p1, logic rf, logic [9:0] exp);
        vec_t v;
        v.rst = rst;
        v.p0  = p0;
        v.p1  = p1;
        v.rf  = rf;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        int ng, ns, np;
        @(posedge mcb_clk);
        #1;
        cyc++;
        ng = int'(p0_gnt) + int'(p1_gnt) + int'(ref_gnt);
        np = int'(p0_gnt) + int'(p1_gnt);
        ns = int'(c_rd) + int'(c_rda) + int'(c_wr) + int'(c_wra);
        n_total++;
        if (ng <= 1 && ns == np) n_pass++;
        else $display("FAIL grant_invariant cyc %0d: grants %0d strobes %0d port_grants %0d", cyc, ng, ns, np);
    endtask

    task automatic wait_evt(input int maxc, output int at);
        int k;
        k  = 0;
        at = -1;
        while (k < maxc) begin
            step();
            k++;
            if (p0_gnt || p1_gnt || ref_gnt) begin
                at = cyc;
                break;
            end
        end
        n_total++;
        if (at >= 0) n_pass++;
        else $display("FAIL wait_grant: no grant within %0d cycles, required one", maxc);
    endtask

    task automatic do_reset();
        mcb_rst = 1'b1;
        p0_req  = 1'b0;
        p1_req  = 1'b0;
        ref_req = 1'b0;
        step();
        mcb_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t, prev;

        tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, {3'b000, 4'b0000, 2'd0, 1'b0}));
        tbl.push_back(mk(0, 5'b10001, 5'b00000, 0, {3'b100, 4'b1000, 2'd1, 1'b1}));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, 5'b00000, 5'b10000, 0, {3'b000, 4'b0000, 2'd1, 1'b1}));
        tbl.push_back(mk(0, 5'b00000, 5'b10000, 0, {3'b000, 4'b0000, 2'd1, 1'b0}));
        tbl.push_back(mk(0, 5'b00000, 5'b10000, 0, {3'b010, 4'b1000, 2'd0, 1'b1}));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 0, {3'b000, 4'b0000, 2'd0, 1'b1}));
        tbl.push_back(mk(1, 5'b11111, 5'b00000, 0, {3'b000, 4'b0000, 2'd0, 1'b0}));
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 0, {3'b100, 4'b0001, 2'd3, 1'b1}));
        tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, {3'b000, 4'b0000, 2'd0, 1'b0}));
        tbl.push_back(mk(0, 5'b00000, 5'b11010, 0, {3'b010, 4'b0010, 2'd2, 1'b1}));
        tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, {3'b000, 4'b0000, 2'd0, 1'b0}));
        tbl.push_back(mk(0, 5'b10100, 5'b00000, 0, {3'b100, 4'b0100, 2'd0, 1'b1}));

        foreach (tbl[i]) begin
            mcb_rst = tbl[i].rst;
            {p0_req, p0_wr, p0_ap, p0_bst_num} = tbl[i].p0;
            {p1_req, p1_wr, p1_ap, p1_bst_num} = tbl[i].p1;
            ref_req = tbl[i].rf;
            step();
            chk($sformatf("vec%0d", i), int'(obs), int'(tbl[i].exp));
        end

        // Both ports reading continuously: p0 first, then strict alternation 4 cycles apart.
        do_reset();
        {p0_req, p0_wr, p0_ap, p0_bst_num} = 5'b10000;
        {p1_req, p1_wr, p1_ap, p1_bst_num} = 5'b10000;
        prev = cyc;
        wait_evt(10, t0);
        chk("alt_first_latency", t0 - prev, 1);
        chk("alt_first_p0", int'(p0_gnt), 1);
        prev = t0;
        for (int k = 1; k <= 5; k++) begin
            wait_evt(20, t);
            chk($sformatf("alt_p1_gnt_%0d", k), int'(p1_gnt), k % 2);
            chk($sformatf("alt_spacing_%0d", k), t - prev, 4);
            prev = t;
        end

        // p0 reads and p1 writes held: read->write 8 apart, write->read 6 apart.
        do_reset();
        {p0_req, p0_wr, p0_ap, p0_bst_num} = 5'b10000;
        {p1_req, p1_wr, p1_ap, p1_bst_num} = 5'b11000;
        wait_evt(10, t0);
        chk("turn_first_rd", int'(c_rd), 1);
        prev = t0;
        for (int k = 1; k <= 4; k++) begin
            wait_evt(30, t);
            chk($sformatf("turn_wr_%0d", k), int'(c_wr), k % 2);
            chk($sformatf("turn_spacing_%0d", k), t - prev, (k % 2 == 1) ? 8 : 6);
            prev = t;
        end

        // Refresh requested during a 16-cycle write burst; read follows refresh with no turnaround.
        do_reset();
        {p0_req, p0_wr, p0_ap, p0_bst_num} = 5'b11011;
        wait_evt(10, t0);
        chk("ref_burst_wr", int'(c_wr), 1);
        chk("ref_burst_bst", int'(c_bst_num), 3);
        p0_req  = 1'b0;
        ref_req = 1'b1;
        wait_evt(40, t);
        chk("ref_gnt", int'(ref_gnt), 1);
        chk("ref_gnt_delay", t - t0, 16);
        chk("ref_hold_bst", int'(c_bst_num), 3);
        ref_req = 1'b0;
        {p0_req, p0_wr, p0_ap, p0_bst_num} = 5'b10000;
        prev = t;
        wait_evt(40, t);
        chk("after_ref_rd", int'(c_rd), 1);
        chk("after_ref_delay", t - prev, 8);

        // Reset pulsed mid-burst: outputs clear, then held p1 wins immediately.
        do_reset();
        {p0_req, p0_wr, p0_ap, p0_bst_num} = 5'b10011;
        wait_evt(10, t0);
        chk("rst_burst_p0", int'(p0_gnt), 1);
        p0_req = 1'b0;
        {p1_req, p1_wr, p1_ap, p1_bst_num} = 5'b10001;
        for (int k = 0; k < 5; k++) step();
        chk("rst_busy_before", int'(arb_busy), 1);
        mcb_rst = 1'b1;
        step();
        chk("rst_outputs_zero", int'(obs), 0);
        mcb_rst = 1'b0;
        step();
        chk("rst_release_p1", int'(obs), int'({3'b010, 4'b1000, 2'd1, 1'b1}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mcb_cmd_arb.md
MCB_CMD_ARB -- requirements
Module: mcb_cmd_arb

Interface
REQ-001 SHALL have parameter P_RW_GAP, default 4, extra idle cycles on a read-to-write direction change (covers CL+1).
REQ-002 SHALL have parameter P_WR_GAP, default 2, extra idle cycles on a write-to-read direction change.
REQ-003 SHALL have parameter P_RFC, default 7, cycles the block stays in REF after a refresh grant; legal range 1..31.
REQ-004 SHALL have ports, listed as name, direction, width, meaning:
- mcb_clk  in  1  sole clock; all logic on its rising edge.
- mcb_rst  in  1  reset, synchronous, active-high.
- p0_req, p1_req  in  1  port request; level, held until that port's grant.
- p0_wr, p1_wr  in  1  1 = write, 0 = read; held with req.
- p0_ap, p1_ap  in  1  auto-precharge; held with req.
- p0_bst_num, p1_bst_num  in  2  burst number; held with req.
- ref_req  in  1  refresh request; level.
- p0_gnt, p1_gnt  out  1  one-cycle grant pulse.
- ref_gnt  out  1  one-cycle refresh grant; doubles as the refresh command strobe.
- c_rd, c_rda, c_wr, c_wra  out  1  one-cycle command strobes to data/command control.
- c_bst_num  out  2  burst number of the issued command.
- arb_busy  out  1  1 when state is not IDLE.

Function
REQ-005 SHALL implement an FSM with four states: IDLE, BUSY (data burst occupying the bus), TURN (direction-change gap) and REF (refresh recovery).
REQ-006 SHALL, in IDLE, evaluate requests each cycle in priority order:
- ref_req first;
- then p0/p1 by round-robin, pointer initially favouring p0.
REQ-007 SHALL register all outputs: a decision in cycle N appears on the outputs in cycle N+1.
REQ-008 SHALL, on a port grant, assert in the same cycle:
- exactly one of pX_gnt;
- exactly one command strobe, selected by wr/ap: c_rd (0/0), c_rda (0/1), c_wr (1/0), c_wra (1/1);
- c_bst_num = the granted port's bst_num.
REQ-009 SHALL hold c_bst_num at its last issued value when no command is strobed.
REQ-010 SHALL toggle the round-robin pointer to the other port after every port grant; the pointer SHALL NOT change on a refresh grant.
REQ-011 SHALL, on a port grant, enter BUSY and load a 5-bit down-counter so that the next command strobe occurs no earlier than (bst_num+1)*4 cycles after the granted strobe (4, 8, 12 or 16).
REQ-012 SHALL leave BUSY at counter expiry:
- to IDLE if the next winning request has the same direction as the last command, or there is no request, giving back-to-back strobes exactly (bst_num+1)*4 cycles apart;
- to TURN otherwise.
REQ-013 SHALL remain in TURN for P_RW_GAP cycles (last command read) or P_WR_GAP cycles (last command write), then return to IDLE.
REQ-014 SHALL issue no command strobe while in BUSY, TURN or REF.
REQ-015 SHALL never assert more than one of p0_gnt, p1_gnt, ref_gnt in any cycle.
REQ-016 SHALL grant ref_req only from IDLE, i.e. only after any outstanding burst and turnaround have completed.
REQ-017 SHALL enter REF on a refresh grant and stay there P_RFC cycles, then return to IDLE with direction history cleared: the next command needs no TURN.
REQ-018 SHALL re-evaluate requests in the cycle the FSM returns to IDLE; a request held throughout is granted without an extra idle cycle.
REQ-019 SHALL, when p0_req and p1_req rise in the same cycle, grant per the pointer only; the loser stays pending until its own grant.
REQ-020 SHALL ignore request deassertion while the request is pending: no grant is issued for a dropped request, and no error is flagged.

Reset
REQ-021 SHALL, while mcb_rst = 1 at a clock edge:
- drive every output low, with c_bst_num = 0;
- set state to IDLE, counter to 0, round-robin pointer to p0, direction history cleared.
REQ-022 SHALL abort any burst, turnaround or refresh in progress when reset is asserted mid-operation, with no further strobes until reset is released.
REQ-023 SHALL accept a request in the first cycle after reset is released.

Verification
REQ-024 Single read: p0 read, bst_num=1 -> one cycle after the request, p0_gnt=1 with c_rd=1 and c_bst_num=1; next grant no earlier than 8 cycles later.
REQ-025 Both ports requesting continuously, both reads, bst_num=0 -> grants alternate p0, p1, p0, ... with strobes exactly 4 cycles apart.
REQ-026 p0 read bst_num=0, then p1 write -> c_wr exactly 4+4 = 8 cycles after c_rd; write then read -> 4+2 = 6 cycles apart.
REQ-027 ref_req during a bst_num=3 burst -> ref_gnt 16 cycles after the burst strobe; no command strobe for the next 7 cycles; the next read is issued without TURN.
REQ-028 mcb_rst pulsed in the middle of a burst -> all outputs 0 in the following cycle; a held p1_req is granted first, since the pointer resets to p0 and only p1 is requesting.
REQ-029 Random stress -> at most one grant per cycle, strobe count equals grant count, and the spacing rules of REQ-011 and REQ-013 hold.
